// File: rtl/intersection_car_queue_pkg.sv
// rtl/intersection_car_queue_pkg.sv - shared lane state encoding and default sizing
package intersection_car_queue_pkg;

    typedef enum logic {
        LANE_IDLE  = 1'b0,
        LANE_CROSS = 1'b1
    } lane_state_t;

    localparam int DEFAULT_CNT_W         = 4;
    localparam int DEFAULT_DEPART_CYCLES = 3;

endpackage

// File: rtl/intersection_car_queue_lane_queue.sv
// rtl/intersection_car_queue_lane_queue.sv - one direction: queue counter, crossing timer, depart pulse
import intersection_car_queue_pkg::*;

module lane_queue #(
    parameter int CNT_W         = DEFAULT_CNT_W,
    parameter int DEPART_CYCLES = DEFAULT_DEPART_CYCLES
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             arrive,
    input  logic             green,
    output logic [CNT_W-1:0] count,
    output logic             car,
    output logic             depart,
    output logic             overflow
);

    localparam int TMR_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DEPART_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    lane_state_t      state, state_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic             depart_now;
    logic             depart_q;

    // State register: lane FSM and crossing timer
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= LANE_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Next state: start a crossing on green with a backlog, abort when green drops,
    // release the car when the timer has run out while still green
    always_comb begin
        state_next = state;
        timer_next = timer;
        depart_now = 1'b0;
        case (state)
            LANE_IDLE: begin
                if (green && (count != '0)) begin
                    state_next = LANE_CROSS;
                    timer_next = TMR_LOAD;
                end
            end
            LANE_CROSS: begin
                if (!green) begin
                    state_next = LANE_IDLE;
                end else if (timer != '0) begin
                    timer_next = timer - TMR_W'(1);
                end else begin
                    depart_now = 1'b1;
                    state_next = LANE_IDLE;
                end
            end
            default: state_next = LANE_IDLE;
        endcase
    end

    // Queue depth, registered depart pulse and sticky drop flag; a simultaneous
    // arrival and departure cancel, so a full queue never overflows on a depart cycle
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count    <= '0;
            depart_q <= 1'b0;
            overflow <= 1'b0;
        end else begin
            depart_q <= depart_now;
            if (arrive && !depart_now) begin
                if (count == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (!arrive && depart_now) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Outputs: car-present follows the count register with no extra latency
    always_comb begin
        car    = (count != '0);
        depart = depart_q;
    end

endmodule

// File: rtl/intersection_car_queue.sv
// rtl/intersection_car_queue.sv - EW/NS car queues driven by the light controller greens
import intersection_car_queue_pkg::*;

module intersection_car_queue #(
    parameter int CNT_W         = DEFAULT_CNT_W,
    parameter int DEPART_CYCLES = DEFAULT_DEPART_CYCLES
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_Ewarrive,
    input  logic             i_Nsarrive,
    input  logic             i_Ewgreen,
    input  logic             i_Nsgreen,
    output logic             o_Ewcar,
    output logic             o_Nscar,
    output logic [CNT_W-1:0] o_Ewcount,
    output logic [CNT_W-1:0] o_Nscount,
    output logic             o_Ewdepart,
    output logic             o_Nsdepart,
    output logic             o_overflow,
    output logic             o_conflict
);

    logic conflict_now;
    logic ew_green, ns_green;
    logic ew_overflow, ns_overflow;

    // Both greens at once is a controller fault: neither lane may treat it as green
    always_comb begin
        conflict_now = i_Ewgreen & i_Nsgreen;
        ew_green     = i_Ewgreen & ~conflict_now;
        ns_green     = i_Nsgreen & ~conflict_now;
        o_overflow   = ew_overflow | ns_overflow;
    end

    // Sticky record of any conflicting-green cycle
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_conflict <= 1'b0;
        end else if (conflict_now) begin
            o_conflict <= 1'b1;
        end
    end

    lane_queue #(.CNT_W(CNT_W), .DEPART_CYCLES(DEPART_CYCLES)) u_ew (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .arrive   (i_Ewarrive),
        .green    (ew_green),
        .count    (o_Ewcount),
        .car      (o_Ewcar),
        .depart   (o_Ewdepart),
        .overflow (ew_overflow)
    );

    lane_queue #(.CNT_W(CNT_W), .DEPART_CYCLES(DEPART_CYCLES)) u_ns (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .arrive   (i_Nsarrive),
        .green    (ns_green),
        .count    (o_Nscount),
        .car      (o_Nscar),
        .depart   (o_Nsdepart),
        .overflow (ns_overflow)
    );

endmodule
